// File: rtl/avg_window.sv
// Moving-average filter over the last 2**LOG2_DEPTH accepted samples.
// Running sum is updated in O(1) per sample; the average is an exact shift.
module avg_window #(
  parameter int WIDTH      = 8,
  parameter int LOG2_DEPTH = 2,
  parameter bit SIGNED     = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             clear_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = WIDTH + LOG2_DEPTH;
  localparam int CNT_W = LOG2_DEPTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0]      mem_reg [DEPTH];
  logic [LOG2_DEPTH-1:0] wp_reg;
  logic [SUM_W-1:0]      sum_reg;
  logic [SUM_W-1:0]      sum_next;
  logic [CNT_W-1:0]      cnt_reg;
  logic [CNT_W-1:0]      cnt_next;
  logic [WIDTH-1:0]      data_reg;
  logic                  valid_reg;
  logic                  full_reg;

  logic                  accept;
  logic [WIDTH-1:0]      old_sample;
  logic [SUM_W-1:0]      new_ext;
  logic [SUM_W-1:0]      old_ext;
  logic [DEPTH-1:0]      slot_we;

  assign accept     = valid_i & ~clear_i;
  assign old_sample = mem_reg[wp_reg];

  generate
    if (SIGNED) begin : g_sext
      assign new_ext = {{LOG2_DEPTH{data_i[WIDTH-1]}}, data_i};
      assign old_ext = {{LOG2_DEPTH{old_sample[WIDTH-1]}}, old_sample};
    end else begin : g_zext
      assign new_ext = {{LOG2_DEPTH{1'b0}}, data_i};
      assign old_ext = {{LOG2_DEPTH{1'b0}}, old_sample};
    end
  endgenerate

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
    assign slot_we[gi] = accept && (wp_reg == LOG2_DEPTH'(gi));
  end

  assign sum_next = sum_reg + new_ext - old_ext;
  assign cnt_next = (cnt_reg == DEPTH_CNT) ? cnt_reg : cnt_reg + 1'b1;

  // Empty slots must read as 0 so the fill phase averages against zeros.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst_ni || clear_i) begin
        mem_reg[i] <= '0;
      end else if (slot_we[i]) begin
        mem_reg[i] <= data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wp_reg    <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      full_reg  <= 1'b0;
    end else if (clear_i) begin
      wp_reg    <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
      full_reg  <= 1'b0;
    end else if (valid_i) begin
      wp_reg    <= wp_reg + 1'b1;
      sum_reg   <= sum_next;
      cnt_reg   <= cnt_next;
      // Dropping the low LOG2_DEPTH bits is the floor shift for both signed
      // and unsigned sums once truncated to WIDTH.
      data_reg  <= sum_next[SUM_W-1 -: WIDTH];
      valid_reg <= 1'b1;
      full_reg  <= (cnt_next == DEPTH_CNT);
    end else begin
      valid_reg <= 1'b0;
    end
  end

  assign valid_o = valid_reg;
  assign data_o  = data_reg;
  assign full_o  = full_reg;

endmodule

// File: tb/tb_avg_window.sv
// Bench for avg_window: four parameterisations share one stimulus stream and
// are checked against directed values and a queue-based averaging model.
module tb_avg_window;

  localparam int NI = 4;
  // instance 0: signed L=2, 1: unsigned L=2, 2: signed L=1, 3: signed L=3
  localparam int LG [NI] = '{2, 2, 1, 3};
  localparam bit SG [NI] = '{1'b1, 1'b0, 1'b1, 1'b1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data = 8'd0;
  logic       clear = 1'b0;

  logic [7:0] dout [NI];
  logic       vout [NI];
  logic       fout [NI];

  int checks = 0;
  int errors = 0;

  logic [7:0] hist [$];
  logic [7:0] exp_data [NI];
  logic       exp_valid;
  logic       exp_full [NI];

  always #5 clk = ~clk;

  avg_window #(.WIDTH(8), .LOG2_DEPTH(2), .SIGNED(1'b1)) u_s2 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(data), .clear_i(clear),
    .valid_o(vout[0]), .data_o(dout[0]), .full_o(fout[0]));
  avg_window #(.WIDTH(8), .LOG2_DEPTH(2), .SIGNED(1'b0)) u_u2 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(data), .clear_i(clear),
    .valid_o(vout[1]), .data_o(dout[1]), .full_o(fout[1]));
  avg_window #(.WIDTH(8), .LOG2_DEPTH(1), .SIGNED(1'b1)) u_s1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(data), .clear_i(clear),
    .valid_o(vout[2]), .data_o(dout[2]), .full_o(fout[2]));
  avg_window #(.WIDTH(8), .LOG2_DEPTH(3), .SIGNED(1'b1)) u_s3 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(data), .clear_i(clear),
    .valid_o(vout[3]), .data_o(dout[3]), .full_o(fout[3]));

  // Mean of the last DEPTH samples (zeros fill missing slots), floored.
  function automatic logic [7:0] ref_avg(input int k);
    int depth = 1 << LG[k];
    int n = (hist.size() < depth) ? hist.size() : depth;
    int s = 0;
    int q;
    logic [31:0] qv;
    for (int i = hist.size() - n; i < hist.size(); i++)
      s += SG[k] ? int'($signed(hist[i])) : int'(hist[i]);
    q = s / depth;
    if (s < 0 && (s % depth) != 0) q = q - 1;
    qv = q;
    return qv[7:0];
  endfunction

  task automatic model_update(input logic r, input logic v, input logic [7:0] d, input logic c);
    if (!r) begin
      hist.delete();
      exp_valid = 1'b0;
      for (int k = 0; k < NI; k++) exp_data[k] = 8'd0;
    end else if (c) begin
      hist.delete();
      exp_valid = 1'b0;
    end else if (v) begin
      hist.push_back(d);
      if (hist.size() > 8) void'(hist.pop_front());
      exp_valid = 1'b1;
      for (int k = 0; k < NI; k++) exp_data[k] = ref_avg(k);
    end else begin
      exp_valid = 1'b0;
    end
    for (int k = 0; k < NI; k++) exp_full[k] = (hist.size() >= (1 << LG[k]));
  endtask

  // One clock of stimulus; outputs are then sampled 1 time unit after the edge.
  task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic c);
    rst_n = r; valid = v; data = d; clear = c;
    @(posedge clk);
    #1;
    model_update(r, v, d, c);
  endtask

  task automatic test_reset;
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (dout[k] !== 8'd0 || vout[k] !== 1'b0 || fout[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d] data=%0d valid=%b full=%b required 0/0/0", k, dout[k], vout[k], fout[k]);
      end
    end
  endtask

  task automatic test_fill_wrap;
    logic [7:0] seq [5] = '{8'd4, 8'd8, 8'd12, 8'd16, 8'd16};
    logic [7:0] e2 [5] = '{8'd1, 8'd3, 8'd6, 8'd10, 8'd13};
    logic [7:0] e1 [5] = '{8'd2, 8'd6, 8'd10, 8'd14, 8'd16};
    logic [7:0] e3 [5] = '{8'd0, 8'd1, 8'd3, 8'd5, 8'd7};
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, seq[i], 1'b0);
      checks++;
      if (dout[0] !== e2[i] || vout[0] !== 1'b1 || fout[0] !== (i >= 3)) begin
        errors++;
        $display("FAIL fill_l2[%0d] data=%0d valid=%b full=%b required %0d/1/%b", i, dout[0], vout[0], fout[0], e2[i], i >= 3);
      end
      checks++;
      if (dout[2] !== e1[i] || fout[2] !== (i >= 1)) begin
        errors++;
        $display("FAIL fill_l1[%0d] data=%0d full=%b required %0d/%b", i, dout[2], fout[2], e1[i], i >= 1);
      end
      checks++;
      if (dout[3] !== e3[i] || fout[3] !== 1'b0) begin
        errors++;
        $display("FAIL fill_l3[%0d] data=%0d full=%b required %0d/0", i, dout[3], fout[3], e3[i]);
      end
    end
  endtask

  task automatic test_signed_floor;
    logic [7:0] seq [4] = '{8'hFF, 8'h80, 8'h80, 8'h80};
    logic [7:0] exp [4] = '{8'hFF, 8'hDF, 8'hBF, 8'h9F};
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, seq[i], 1'b0);
      checks++;
      if (dout[0] !== exp[i]) begin
        errors++;
        $display("FAIL signed_floor[%0d] data=%h required %h", i, dout[0], exp[i]);
      end
    end
  endtask

  task automatic test_unsigned_extremes;
    logic [7:0] seq [5] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd0};
    logic [7:0] exp [5] = '{8'd63, 8'd127, 8'd191, 8'd255, 8'd191};
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, seq[i], 1'b0);
      checks++;
      if (dout[1] !== exp[i]) begin
        errors++;
        $display("FAIL unsigned[%0d] data=%0d required %0d", i, dout[1], exp[i]);
      end
    end
  endtask

  task automatic test_stalls;
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    drive(1'b1, 1'b1, 8'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 8'($urandom), 1'b0);
      checks++;
      if (vout[0] !== 1'b0 || dout[0] !== 8'd1) begin
        errors++;
        $display("FAIL stall_gap[%0d] valid=%b data=%0d required 0/1", i, vout[0], dout[0]);
      end
    end
    drive(1'b1, 1'b1, 8'd8, 1'b0);
    checks++;
    if (vout[0] !== 1'b1 || dout[0] !== 8'd3) begin
      errors++;
      $display("FAIL stall_resume valid=%b data=%0d required 1/3", vout[0], dout[0]);
    end
  endtask

  task automatic test_clear;
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    drive(1'b1, 1'b1, 8'd40, 1'b0);
    drive(1'b1, 1'b1, 8'd40, 1'b0);
    drive(1'b1, 1'b1, 8'd100, 1'b1);
    checks++;
    if (vout[0] !== 1'b0 || fout[0] !== 1'b0 || dout[0] !== 8'd20) begin
      errors++;
      $display("FAIL clear valid=%b full=%b data=%0d required 0/0/20", vout[0], fout[0], dout[0]);
    end
    drive(1'b1, 1'b1, 8'd8, 1'b0);
    checks++;
    if (vout[0] !== 1'b1 || dout[0] !== 8'd2) begin
      errors++;
      $display("FAIL after_clear valid=%b data=%0d required 1/2", vout[0], dout[0]);
    end
  endtask

  task automatic test_reset_midstream;
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 8'd100, 1'b0);
    checks++;
    if (fout[0] !== 1'b1 || dout[0] !== 8'd100) begin
      errors++;
      $display("FAIL pre_reset full=%b data=%0d required 1/100", fout[0], dout[0]);
    end
    drive(1'b0, 1'b1, 8'd100, 1'b0);
    checks++;
    if (dout[0] !== 8'd0 || vout[0] !== 1'b0 || fout[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset data=%0d valid=%b full=%b required 0/0/0", dout[0], vout[0], fout[0]);
    end
    drive(1'b1, 1'b1, 8'd20, 1'b0);
    checks++;
    if (dout[0] !== 8'd5 || fout[0] !== 1'b0) begin
      errors++;
      $display("FAIL post_reset data=%0d full=%b required 5/0", dout[0], fout[0]);
    end
  endtask

  task automatic test_random;
    logic       r, v, c;
    logic [7:0] d;
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 59) != 0);
      c = ($urandom_range(0, 24) == 0);
      v = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       d = 8'h80;
        1:       d = 8'hFF;
        default: d = 8'($urandom);
      endcase
      drive(r, v, d, c);
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (dout[k] !== exp_data[k] || vout[k] !== exp_valid || fout[k] !== exp_full[k]) begin
          errors++;
          $display("FAIL random[%0d] inst=%0d data=%0d valid=%b full=%b required %0d/%b/%b",
                   n, k, dout[k], vout[k], fout[k], exp_data[k], exp_valid, exp_full[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_wrap();
    test_signed_floor();
    test_unsigned_extremes();
    test_stalls();
    test_clear();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avg_window.md
# avg_window

Parametrised moving-average filter over the last `2**LOG2_DEPTH` accepted samples, with selectable signed/unsigned arithmetic and a valid handshake. It sits in the sample datapath between a source that may stall and a downstream consumer that samples only when `valid_o` is high. It generalises the fixed 3-tap averager:

- power-of-two window depth, so division is an exact shift;
- O(1) running-sum update per sample;
- explicit fill status;
- synchronous clear.

## Interface
- `WIDTH`, default 8: sample width in bits, ≥ 2.
- `LOG2_DEPTH`, default 2: window depth is `DEPTH = 2**LOG2_DEPTH`; range 1..6.
- `SIGNED`, default 1: 1 = two's-complement samples and result; 0 = unsigned.
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_ni`  in  1  synchronous, active-low reset.
- `valid_i`  in  1  `data_i` is a sample to accept this cycle.
- `data_i`  in  WIDTH  input sample.
- `clear_i`  in  1  synchronous flush of window history.
- `valid_o`  out  1  `data_o` updated this cycle (single-cycle pulse per accepted sample).
- `data_o`  out  WIDTH  window average.
- `full_o`  out  1  at least `DEPTH` samples accepted since the last reset or clear.

## Operation
- **Storage:** circular buffer `buf[0..DEPTH-1]` of `WIDTH` bits, write pointer `wp` (LOG2_DEPTH bits, wraps `DEPTH-1` -> 0), running sum `sum` of `WIDTH+LOG2_DEPTH` bits, fill counter `cnt` saturating at `DEPTH`.
- **Accept:** on a cycle with `valid_i=1` and `clear_i=0`:
  - `old = buf[wp]`; `buf[wp] <= data_i`; `wp <= wp+1`;
  - `sum_n = sum + ext(data_i) - ext(old)`; `sum <= sum_n`;
  - `data_o <= sum_n >>> LOG2_DEPTH`, truncated to WIDTH; `valid_o <= 1`;
  - `cnt <= min(cnt+1, DEPTH)`.
- **Sign extension:** `ext()` is sign extension when `SIGNED=1` and zero extension otherwise. The shift is arithmetic when signed, so the result rounds toward negative infinity (floor). The shift is logical when unsigned.
- **Result range:** the result always fits in WIDTH bits because it is the mean of in-range values. No saturation logic is needed.
- **Fill phase:** empty slots hold 0, so before the window is full the output equals (sum of accepted samples)/DEPTH. This is intended; consumers qualify the output with `full_o`.
- **Idle:** on a cycle with `valid_i=0` and `clear_i=0`:
  - `valid_o <= 0`;
  - `data_o`, `buf`, `wp`, `sum` and `cnt` hold.
- **Clear:** when `clear_i=1`, irrespective of `valid_i`:
  - all `buf` entries, `sum`, `wp` and `cnt` are set to 0;
  - `valid_o <= 0`; `data_o` holds its last value;
  - a sample presented in the same cycle is dropped.
- **Status:** `full_o = (cnt == DEPTH)` is registered. It stays 1 until reset or clear.
- **Priority:** `rst_ni=0` > `clear_i` > `valid_i`.

## Timing
- **Reset:** with `rst_ni=0` at a rising edge, every register is 0 after that edge: `data_o=0`, `valid_o=0`, `full_o=0`, buffer, `sum`, `wp`, `cnt`. Reset mid-stream discards all history; the first sample after reset is treated as sample 1 of an empty window.
- **Latency:** one cycle. A sample accepted at edge t produces `data_o`/`valid_o` visible after edge t, and the output includes that sample.
- **Throughput:** one sample per cycle; back-to-back `valid_i` is allowed and there is no backpressure.
- **Fill:** `full_o` rises together with the `valid_o` of the DEPTH-th accepted sample.
- **Wrap:** when `wp` wraps, the oldest sample (the one accepted DEPTH acceptances earlier) is subtracted in the same cycle as the new sample is added. Gaps in `valid_i` do not age the window.
- **Clear:** `clear_i` at edge t means the sample accepted at t+1 sees an empty window.

## Test plan
- **Fill and wrap (signed, W=8, L=2):** after reset, send 4, 8, 12, 16, 16 back-to-back -> `data_o` = 1, 3, 6, 10, 13 on consecutive cycles. `full_o` = 1 from the 4th output onward.
- **Signed floor (signed, W=8, L=2):** send -1 -> `data_o` = 0xFF (-1). Then send -128 three times -> `data_o` = -33 (0xDF), -65 (0xBF), -97 (0x9F). No overflow.
- **Unsigned extremes (unsigned, W=8, L=2):** send 255 four times -> 63, 127, 191, 255. Then send 0 -> 191.
- **Stalls:** send 4, then hold `valid_i=0` for 5 cycles, then send 8 -> `valid_o` is low during the gap with `data_o` holding 1; then `data_o` = 3.
- **Clear:**
  - Send 40, 40, then `clear_i=1` with `valid_i=1` and `data_i`=100 -> the sample is dropped, `valid_o=0`, `full_o=0`.
  - Then send 8 -> `data_o` = 2.
- **Reset mid-stream:** full window of 100s, then `rst_ni=0` for 1 cycle -> all outputs 0. Then send 20 -> `data_o` = 5, `full_o=0`. Also repeat the fill/wrap scenario at L=1 and L=3.
